// File: rtl/wb_mem_pkg.sv
// Shared types and helpers for the WISHBONE slave memory controller.
package wb_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} wb_mem_state_t;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    // Byte address where slave `id` starts when every slave owns `sz` bytes.
    function automatic logic [31:0] wb_base(input logic [31:0] id, input logic [31:0] sz);
        return id * sz;
    endfunction

endpackage

// File: rtl/wb_mem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
module wb_mem_array
    import wb_mem_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [WB_SEL_W-1:0]  be,
    input  logic [AW-1:0]        addr,
    input  logic [WB_DATA_W-1:0] wdata,
    output logic [WB_DATA_W-1:0] rdata
);

    logic [WB_DATA_W-1:0] mem [2**AW];

    // Read-before-write: rdata shows the old word when both happen on one edge.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WB_SEL_W; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_slave_mem_ctrl.sv
// WISHBONE B3 classic-cycle slave memory with programmable wait states.
// Define WB_SLAVE_MEM_ERR_EN to terminate misaligned or empty-select accesses with err_o.
module wb_slave_mem_ctrl
    import wb_mem_pkg::*;
#(
    parameter int unsigned WB_ID               = 0,
    parameter logic [31:0] SLAVE_ADDR_SPACE_SZ = 32'h00100000,
    parameter int          MEM_WD_SIZE         = 18,
    parameter int          WAIT_STATES         = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          adr_i,
    input  logic [WB_DATA_W-1:0] dat_i,
    output logic [WB_DATA_W-1:0] dat_o,
    input  logic                 we_i,
    input  logic [WB_SEL_W-1:0]  sel_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    output logic                 ack_o,
    output logic                 err_o,
    output logic [1:0]           dbg_state
);

    localparam logic [31:0] WIN_MASK = ~(SLAVE_ADDR_SPACE_SZ - 32'd1);
    localparam logic [31:0] WIN_BASE = wb_base(32'(WB_ID), SLAVE_ADDR_SPACE_SZ);

    wb_mem_state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic [MEM_WD_SIZE-1:0] adr_q;
    logic [WB_DATA_W-1:0]   dat_q;
    logic [WB_SEL_W-1:0]    sel_q;
    logic                   we_q;
    logic                   err_q;
    logic [WB_DATA_W-1:0]   rdat_q;
    logic [WB_DATA_W-1:0]   mem_rdata;
    logic [MEM_WD_SIZE-1:0] mem_addr;

    logic hit, accept, in_ack, mem_we, rd_present;

    // Handshake: a request is cyc_i&stb_i inside our window, taken only in IDLE;
    // it ends with a single-cycle ack_o/err_o, and the master may drop the
    // request during WAIT to abandon it without side effects.
    assign hit    = (adr_i & WIN_MASK) == WIN_BASE;
    assign accept = (state == IDLE) && cyc_i && stb_i && hit;
    assign in_ack = (state == ACK) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt   = 4'(WAIT_STATES);
                    state_nxt = (WAIT_STATES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                if (!(cyc_i && stb_i)) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            adr_q <= adr_i[MEM_WD_SIZE+1:2];
            dat_q <= dat_i;
            sel_q <= sel_i;
            we_q  <= we_i;
        end
    end

`ifdef WB_SLAVE_MEM_ERR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)       err_q <= 1'b0;
        else if (accept) err_q <= (adr_i[1:0] != 2'b00) || (sel_i == '0);
    end
`else
    assign err_q = 1'b0;
`endif

    // In IDLE the live address feeds the RAM so a zero-wait read has data at ACK.
    assign mem_addr   = (state == IDLE) ? adr_i[MEM_WD_SIZE+1:2] : adr_q;
    assign mem_we     = in_ack && we_q && !err_q;
    assign rd_present = in_ack && !we_q && !err_q;

    wb_mem_array #(.AW(MEM_WD_SIZE)) u_array (
        .clk   (clk_i),
        .we    (mem_we),
        .be    (sel_q),
        .addr  (mem_addr),
        .wdata (dat_q),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i)           rdat_q <= '0;
        else if (rd_present) rdat_q <= mem_rdata;
    end

    assign dat_o     = rd_present ? mem_rdata : rdat_q;
    assign ack_o     = in_ack && !err_q;
    assign err_o     = in_ack && err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_wb_slave_mem_ctrl.sv
// Self-checking bench: zero-wait slave (dut0) and three-wait slave (dut3), both WB_ID=1.
module tb_wb_slave_mem_ctrl;
  import wb_mem_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] adr = '0, dat_w = '0;
  logic        we = 1'b0, stb = 1'b0, cyc0 = 1'b0, cyc3 = 1'b0;
  logic [3:0]  sel = '0;

  logic [31:0] dat0, dat3;
  logic        ack0, err0, ack3, err3;
  logic [1:0]  st0, st3;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  wb_slave_mem_ctrl #(.WB_ID(1), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat0), .we_i(we),
    .sel_i(sel), .cyc_i(cyc0), .stb_i(stb), .ack_o(ack0), .err_o(err0), .dbg_state(st0)
  );

  wb_slave_mem_ctrl #(.WB_ID(1), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat3), .we_i(we),
    .sel_i(sel), .cyc_i(cyc3), .stb_i(stb), .ack_o(ack3), .err_o(err3), .dbg_state(st3)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: one classic cycle, called and returning on a negedge; lat=0 means no termination
  task automatic wb_cycle(input bit use3, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output int lat, output logic [31:0] rd, output logic saw_err);
    adr = a; dat_w = d; sel = s; we = w; stb = 1'b1;
    if (use3) cyc3 = 1'b1; else cyc0 = 1'b1;
    lat = 0; rd = '0; saw_err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (use3 ? (ack3 | err3) : (ack0 | err0)) begin
        lat = k;
        rd = use3 ? dat3 : dat0;
        saw_err = use3 ? err3 : err0;
        break;
      end
    end
    cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    adr = 32'h00100000; cyc0 = 1'b1; stb = 1'b1; rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack0); end
      n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err0); end
      n_checks++; if (dat0 !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", dat0); end
      n_checks++; if (st0 !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", st0, IDLE); end
    end
    cyc0 = 1'b0; stb = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd, exp_v; logic e;
    wb_cycle(0, 1'b1, 32'h00100010, 32'hDEADBEEF, 4'hF, lat, rd, e);
    n_checks++; if (lat != 1 || e !== 1'b0) begin n_fail++; $display("FAIL wr_lat: got lat=%0d err=%b want lat=1 err=0", lat, e); end
    exp_q.push_back(32'hDEADBEEF);
    wb_cycle(0, 1'b0, 32'h00100010, 32'h0, 4'hF, lat, rd, e);
    exp_v = exp_q.pop_front();
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL rd_lat: got %0d want 1", lat); end
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL rd_data: got %h want %h", rd, exp_v); end
    n_checks++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL ack_one_cycle: got %b want 0", ack0); end
    n_checks++; if (dat0 !== exp_v) begin n_fail++; $display("FAIL dat_hold: got %h want %h", dat0, exp_v); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] rd, exp_v; logic e;
    wb_cycle(0, 1'b1, 32'h00100010, 32'h11223344, 4'b0101, lat, rd, e);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL lane_wr_lat: got %0d want 1", lat); end
    n_checks++; if (dat0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_keeps_dat: got %h want deadbeef", dat0); end
    exp_q.push_back(32'hDE22BE44);
    wb_cycle(0, 1'b0, 32'h00100010, 32'h0, 4'hF, lat, rd, e);
    exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL lane_rd: got %h want %h", rd, exp_v); end
  endtask

  task automatic test_miss();
    adr = 32'h00000010; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc0 = 1'b1;
    repeat (8) begin
      @(negedge clk);
      n_checks++; if (ack0 !== 1'b0 || err0 !== 1'b0) begin n_fail++; $display("FAIL miss_term: got ack=%b err=%b want 0 0", ack0, err0); end
      n_checks++; if (st0 !== IDLE) begin n_fail++; $display("FAIL miss_state: got %0d want %0d", st0, IDLE); end
    end
    cyc0 = 1'b0; stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd, exp_v; logic e;
    wb_cycle(1, 1'b1, 32'h00100020, 32'h0BADC0DE, 4'hF, lat, rd, e);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL ws3_wr_lat: got %0d want 4", lat); end
    adr = 32'h00100020; dat_w = 32'hCAFEF00D; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc3 = 1'b1;
    @(negedge clk);
    n_checks++; if (st3 !== WAIT) begin n_fail++; $display("FAIL abort_wait: got %0d want %0d", st3, WAIT); end
    @(negedge clk);
    cyc3 = 1'b0; stb = 1'b0;
    repeat (6) begin
      @(negedge clk);
      n_checks++; if (ack3 !== 1'b0 || err3 !== 1'b0) begin n_fail++; $display("FAIL abort_term: got ack=%b err=%b want 0 0", ack3, err3); end
    end
    n_checks++; if (st3 !== IDLE) begin n_fail++; $display("FAIL abort_idle: got %0d want %0d", st3, IDLE); end
    exp_q.push_back(32'h0BADC0DE);
    wb_cycle(1, 1'b0, 32'h00100020, 32'h0, 4'hF, lat, rd, e);
    exp_v = exp_q.pop_front();
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL ws3_rd_lat: got %0d want 4", lat); end
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL abort_data: got %h want %h", rd, exp_v); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd, exp_v; logic e;
    wb_cycle(0, 1'b1, 32'h00100012, 32'h12345678, 4'hF, lat, rd, e);
`ifdef WB_SLAVE_MEM_ERR_EN
    n_checks++; if (lat != 1 || e !== 1'b1) begin n_fail++; $display("FAIL mis_err: got lat=%0d err=%b want 1 1", lat, e); end
    n_checks++; if (dat0 !== 32'hDE22BE44) begin n_fail++; $display("FAIL mis_dat: got %h want de22be44", dat0); end
    exp_q.push_back(32'hDE22BE44);
`else
    n_checks++; if (lat != 1 || e !== 1'b0) begin n_fail++; $display("FAIL mis_ack: got lat=%0d err=%b want 1 0", lat, e); end
    exp_q.push_back(32'h12345678);
`endif
    wb_cycle(0, 1'b1, 32'h00100010, 32'hFFFFFFFF, 4'h0, lat, rd, e);
`ifdef WB_SLAVE_MEM_ERR_EN
    n_checks++; if (lat != 1 || e !== 1'b1) begin n_fail++; $display("FAIL sel0_err: got lat=%0d err=%b want 1 1", lat, e); end
`else
    n_checks++; if (lat != 1 || e !== 1'b0) begin n_fail++; $display("FAIL sel0_ack: got lat=%0d err=%b want 1 0", lat, e); end
`endif
    wb_cycle(0, 1'b0, 32'h00100010, 32'h0, 4'hF, lat, rd, e);
    exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL mis_word: got %h want %h", rd, exp_v); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd, exp_v, va, vb; logic e;
    va = $urandom; vb = $urandom;
    wb_cycle(0, 1'b1, 32'h00100030, va, 4'hF, lat, rd, e);
    wb_cycle(0, 1'b1, 32'h00100034, vb, 4'hF, lat, rd, e);
    exp_q.push_back(va); exp_q.push_back(vb);
    adr = 32'h00100030; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc0 = 1'b1;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_checks++; if (ack0 !== 1'b1 || dat0 !== exp_v) begin n_fail++; $display("FAIL b2b_first: got ack=%b dat=%h want 1 %h", ack0, dat0, exp_v); end
    adr = 32'h00100034;
    @(negedge clk);
    n_checks++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %b want 0", ack0); end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_checks++; if (ack0 !== 1'b1 || dat0 !== exp_v) begin n_fail++; $display("FAIL b2b_second: got ack=%b dat=%h want 1 %h", ack0, dat0, exp_v); end
    cyc0 = 1'b0; stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] mdl [16];
    int lat, idx; logic [31:0] rd, d, exp_v; logic [3:0] s; logic e;
    for (int i = 0; i < 16; i++) begin
      mdl[i] = $urandom;
      wb_cycle(0, 1'b1, 32'h00100100 + 32'(4*i), mdl[i], 4'hF, lat, rd, e);
      n_checks++; if (lat != 1 || e !== 1'b0) begin n_fail++; $display("FAIL fill_lat: got lat=%0d err=%b want 1 0", lat, e); end
    end
    for (int n = 0; n < 24; n++) begin
      idx = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom_range(1, 15));
        wb_cycle(0, 1'b1, 32'h00100100 + 32'(4*idx), d, s, lat, rd, e);
        for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        n_checks++; if (lat != 1 || e !== 1'b0) begin n_fail++; $display("FAIL rnd_wr: got lat=%0d err=%b want 1 0", lat, e); end
      end else begin
        exp_q.push_back(mdl[idx]);
        wb_cycle(0, 1'b0, 32'h00100100 + 32'(4*idx), 32'h0, 4'hF, lat, rd, e);
        exp_v = exp_q.pop_front();
        n_checks++; if (lat != 1 || rd !== exp_v) begin n_fail++; $display("FAIL rnd_rd: got lat=%0d dat=%h want 1 %h", lat, rd, exp_v); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_miss();
    test_abort();
    test_misaligned();
    test_back_to_back();
    test_random();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
